// File: rtl/risc_toy_pkg.sv
// RISC-TOY execute stage shared definitions: opcodes, condition codes,
// the ALU result bundle and the branch condition evaluator.
package risc_toy_pkg;

  localparam int XLEN = 32;

  localparam logic [4:0] OP_ADDI = 5'd0;
  localparam logic [4:0] OP_ADD  = 5'd1;
  localparam logic [4:0] OP_SUB  = 5'd2;
  localparam logic [4:0] OP_NEG  = 5'd3;
  localparam logic [4:0] OP_NOT  = 5'd4;
  localparam logic [4:0] OP_ANDI = 5'd5;
  localparam logic [4:0] OP_ORI  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_MOVI = 5'd10;
  localparam logic [4:0] OP_LSR  = 5'd11;
  localparam logic [4:0] OP_ASR  = 5'd12;
  localparam logic [4:0] OP_SHL  = 5'd13;
  localparam logic [4:0] OP_ROR  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd15;
  localparam logic [4:0] OP_BRL  = 5'd16;
  localparam logic [4:0] OP_J    = 5'd17;
  localparam logic [4:0] OP_JL   = 5'd18;
  localparam logic [4:0] OP_LD   = 5'd19;
  localparam logic [4:0] OP_LDR  = 5'd20;
  localparam logic [4:0] OP_ST   = 5'd21;
  localparam logic [4:0] OP_STR  = 5'd22;

  localparam logic [2:0] COND_NEVER  = 3'd0;
  localparam logic [2:0] COND_ALWAYS = 3'd1;
  localparam logic [2:0] COND_EQ     = 3'd2;
  localparam logic [2:0] COND_NE     = 3'd3;
  localparam logic [2:0] COND_PL     = 3'd4;
  localparam logic [2:0] COND_MI     = 3'd5;

  typedef struct packed {
    logic [31:0] result;
    logic        wen;
    logic        is_load;
    logic        mem_req;
    logic        mem_rw;
    logic [29:0] maddr;
    logic        taken;
    logic [31:0] target;
  } ex_res_t;

  function automatic logic cond_eval(input logic [2:0] cond,
                                     input logic [31:0] v);
    logic t;
    t = 1'b0;
    unique case (1'b1)
      (cond == COND_ALWAYS): t = 1'b1;
      (cond == COND_EQ):     t = (v == 32'd0);
      (cond == COND_NE):     t = (v != 32'd0);
      (cond == COND_PL):     t = !v[31];
      (cond == COND_MI):     t = v[31];
      default:               t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/risc_toy_execute_alu.sv
// RISC-TOY execute datapath: result, shifts, branch resolution and
// memory address formation, purely combinational.
module risc_toy_alu
  import risc_toy_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] imm,
  input  logic [2:0]  cond,
  input  logic [31:0] pc,
  output ex_res_t     res
);

  logic [4:0]  sh;
  logic [63:0] rot;
  logic [31:0] a_imm;
  logic [31:0] pc_imm;
  logic [31:0] link;
  logic        hit;

  assign sh     = b[4:0];
  assign rot    = {a, a} >> sh;
  assign a_imm  = a + imm;
  assign pc_imm = pc + imm;
  assign link   = pc + 32'd4;
  assign hit    = cond_eval(cond, c);

  always_comb begin
    res = '0;
    case (op)
      OP_ADDI: begin res.result = a_imm;          res.wen = 1'b1; end
      OP_ADD:  begin res.result = a + b;          res.wen = 1'b1; end
      OP_SUB:  begin res.result = a - b;          res.wen = 1'b1; end
      OP_NEG:  begin res.result = 32'd0 - b;      res.wen = 1'b1; end
      OP_NOT:  begin res.result = ~b;             res.wen = 1'b1; end
      OP_ANDI: begin res.result = a & imm;        res.wen = 1'b1; end
      OP_ORI:  begin res.result = a | imm;        res.wen = 1'b1; end
      OP_AND:  begin res.result = a & b;          res.wen = 1'b1; end
      OP_OR:   begin res.result = a | b;          res.wen = 1'b1; end
      OP_XOR:  begin res.result = a ^ b;          res.wen = 1'b1; end
      OP_MOVI: begin res.result = imm;            res.wen = 1'b1; end
      OP_LSR:  begin res.result = a >> sh;        res.wen = 1'b1; end
      OP_ASR:  begin
        res.result = $unsigned($signed(a) >>> sh);
        res.wen    = 1'b1;
      end
      OP_SHL:  begin res.result = a << sh;        res.wen = 1'b1; end
      OP_ROR:  begin res.result = rot[31:0];      res.wen = 1'b1; end
      OP_BR:   begin res.taken = hit; res.target = b; end
      OP_BRL:  begin
        res.taken  = hit;
        res.target = b;
        res.result = link;
        res.wen    = 1'b1;
      end
      OP_J:    begin res.taken = 1'b1; res.target = pc_imm; end
      OP_JL:   begin
        res.taken  = 1'b1;
        res.target = pc_imm;
        res.result = link;
        res.wen    = 1'b1;
      end
      // loads report the byte address as their result
      OP_LD, OP_LDR: begin
        res.result  = (op == OP_LD) ? a_imm : pc_imm;
        res.wen     = 1'b1;
        res.is_load = 1'b1;
        res.mem_req = 1'b1;
        res.maddr   = res.result[31:2];
      end
      OP_ST, OP_STR: begin
        res.result  = (op == OP_ST) ? a_imm : pc_imm;
        res.mem_req = 1'b1;
        res.mem_rw  = 1'b1;
        res.maddr   = res.result[31:2];
      end
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/risc_toy_execute.sv
// RISC-TOY execute stage: one registered output slot with valid/ready.
// Optional perf counters enabled by RISC_TOY_EX_PERF_EN.
module risc_toy_execute
  import risc_toy_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic [XLEN-1:0] in_c,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_cond,
  input  logic [4:0]      in_dest,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [4:0]      out_dest,
  output logic            out_wen,
  output logic            out_is_load,
  output logic            out_mem_req,
  output logic            out_mem_rw,
  output logic [29:0]     out_mem_addr,
  output logic [XLEN-1:0] out_mem_wdata,
  output logic            br_taken,
`ifdef RISC_TOY_EX_PERF_EN
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_taken,
`endif
  output logic [XLEN-1:0] br_target
);

  ex_res_t res;
  logic    cap;
  logic    leave;

  risc_toy_alu u_alu (
    .op   (in_op),
    .a    (in_a),
    .b    (in_b),
    .c    (in_c),
    .imm  (in_imm),
    .cond (in_cond),
    .pc   (in_pc),
    .res  (res)
  );

  assign in_ready = !out_valid | out_ready | br_taken;
  // a taken branch swallows wrong-path instructions instead of loading them
  assign cap      = in_valid & in_ready & !br_taken;
  assign leave    = out_valid & out_ready;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_dest      <= '0;
      out_wen       <= 1'b0;
      out_is_load   <= 1'b0;
      out_mem_req   <= 1'b0;
      out_mem_rw    <= 1'b0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
      br_taken      <= 1'b0;
      br_target     <= '0;
    end else if (cap) begin
      out_valid     <= 1'b1;
      out_result    <= res.result;
      out_dest      <= in_dest;
      out_wen       <= res.wen;
      out_is_load   <= res.is_load;
      out_mem_req   <= res.mem_req;
      out_mem_rw    <= res.mem_rw;
      out_mem_addr  <= res.maddr;
      out_mem_wdata <= in_c;
      br_taken      <= res.taken;
      br_target     <= res.target;
    end else if (leave) begin
      out_valid     <= 1'b0;
      br_taken      <= 1'b0;
    end
  end

`ifdef RISC_TOY_EX_PERF_EN
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      perf_retired <= '0;
      perf_taken   <= '0;
    end else if (leave) begin
      perf_retired <= perf_retired + 32'd1;
      if (br_taken) perf_taken <= perf_taken + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_risc_toy_execute.sv
// Randomized self-checking bench for risc_toy_execute against a
// behavioural slot/ISA model.
module tb_risc_toy_execute;
  import risc_toy_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        in_valid, in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_a, in_b, in_c, in_imm, in_pc;
  logic [2:0]  in_cond;
  logic [4:0]  in_dest;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_mem_wdata, br_target;
  logic [4:0]  out_dest;
  logic        out_wen, out_is_load, out_mem_req, out_mem_rw, br_taken;
  logic [29:0] out_mem_addr;
`ifdef RISC_TOY_EX_PERF_EN
  logic [31:0] perf_retired, perf_taken;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] result;
    logic        chk_res;
    logic [4:0]  dest;
    logic        wen, is_load, mem_req, mem_rw, taken;
    logic [31:0] addr, wdata, target;
  } exp_t;

  exp_t m_e;
  logic m_valid = 1'b0;
  int   n_ret = 0;
  int   n_tak = 0;

  risc_toy_execute dut (
    .CLK(CLK), .RSTN(RSTN),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_imm(in_imm), .in_cond(in_cond), .in_dest(in_dest),
    .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest),
    .out_wen(out_wen), .out_is_load(out_is_load),
    .out_mem_req(out_mem_req), .out_mem_rw(out_mem_rw),
    .out_mem_addr(out_mem_addr), .out_mem_wdata(out_mem_wdata),
    .br_taken(br_taken),
`ifdef RISC_TOY_EX_PERF_EN
    .perf_retired(perf_retired), .perf_taken(perf_taken),
`endif
    .br_target(br_target)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_exec(input logic [4:0] op,
      input logic [31:0] a, b, c, imm, input logic [2:0] cond,
      input logic [4:0] dest, input logic [31:0] pc);
    exp_t e;
    int s;
    logic ok;
    s = int'(b % 32);
    ok = (cond == 1) || (cond == 2 && c == 0) || (cond == 3 && c != 0)
      || (cond == 4 && $signed(c) >= 0) || (cond == 5 && $signed(c) < 0);
    e = '{result: 0, chk_res: 0, dest: dest, wen: 0, is_load: 0,
          mem_req: 0, mem_rw: 0, taken: 0, addr: 0, wdata: c, target: 0};
    if (op <= 14) begin
      e.wen = 1; e.chk_res = 1;
      case (op)
        0: e.result = a + imm;
        1: e.result = a + b;
        2: e.result = a - b;
        3: e.result = -b;
        4: e.result = ~b;
        5: e.result = a & imm;
        6: e.result = a | imm;
        7: e.result = a & b;
        8: e.result = a | b;
        9: e.result = a ^ b;
        10: e.result = imm;
        11: e.result = a >> s;
        12: e.result = (a >> s) | ((a[31] && s > 0) ? ~(32'hFFFF_FFFF >> s) : 0);
        13: e.result = a << s;
        default: e.result = (s == 0) ? a : ((a >> s) | (a << (32 - s)));
      endcase
    end else if (op >= 15 && op <= 18) begin
      e.taken  = (op >= 17) ? 1'b1 : ok;
      e.target = (op >= 17) ? pc + imm : b;
      if (op == 16 || op == 18) begin
        e.wen = 1; e.chk_res = 1; e.result = pc + 4;
      end
    end else if (op >= 19 && op <= 22) begin
      e.mem_req = 1;
      e.addr = (op == 19 || op == 21) ? a + imm : pc + imm;
      if (op <= 20) begin
        e.wen = 1; e.is_load = 1; e.chk_res = 1; e.result = e.addr;
      end else e.mem_rw = 1;
    end
    return e;
  endfunction

  task automatic drive(input logic v, input logic [4:0] op,
      input logic [31:0] a, b, c, imm, input logic [2:0] cond,
      input logic [4:0] dest, input logic [31:0] pc);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_c = c;
    in_imm = imm; in_cond = cond; in_dest = dest; in_pc = pc;
  endtask

  task automatic check_out();
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("br_taken", {31'd0, br_taken}, {31'd0, m_valid & m_e.taken});
    if (m_valid) begin
      chk("out_dest", {27'd0, out_dest}, {27'd0, m_e.dest});
      chk("out_wen", {31'd0, out_wen}, {31'd0, m_e.wen});
      chk("out_is_load", {31'd0, out_is_load}, {31'd0, m_e.is_load});
      chk("out_mem_req", {31'd0, out_mem_req}, {31'd0, m_e.mem_req});
      if (m_e.mem_req) begin
        chk("out_mem_rw", {31'd0, out_mem_rw}, {31'd0, m_e.mem_rw});
        chk("out_mem_addr", {2'd0, out_mem_addr}, {2'd0, m_e.addr[31:2]});
        if (m_e.mem_rw) chk("out_mem_wdata", out_mem_wdata, m_e.wdata);
      end
      if (m_e.chk_res) chk("out_result", out_result, m_e.result);
      if (m_e.taken) chk("br_target", br_target, m_e.target);
    end
`ifdef RISC_TOY_EX_PERF_EN
    chk("perf_retired", perf_retired, n_ret);
    chk("perf_taken", perf_taken, n_tak);
`endif
  endtask

  task automatic tick();
    exp_t e;
    logic rdy, capx, leavex;
    e = ref_exec(in_op, in_a, in_b, in_c, in_imm, in_cond, in_dest, in_pc);
    rdy = !m_valid || out_ready || (m_valid && m_e.taken);
    #1 chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    capx = in_valid && rdy && !(m_valid && m_e.taken);
    leavex = m_valid && out_ready;
    @(posedge CLK);
    if (leavex) begin
      n_ret++;
      if (m_e.taken) n_tak++;
    end
    if (capx) begin
      m_valid = 1'b1; m_e = e;
    end else if (leavex) m_valid = 1'b0;
    @(negedge CLK);
    check_out();
  endtask

  initial begin
    RSTN = 1'b0; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    m_e = ref_exec(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge CLK);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_br_taken", {31'd0, br_taken}, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    RSTN = 1'b1;
    @(negedge CLK);

    drive(1, OP_ADD, 7, 32'hFFFF_FFFF, 0, 0, 0, 5'd9, 0); tick();
    chk("t1_result", out_result, 6);
    chk("t1_dest", {27'd0, out_dest}, 9);
    drive(1, OP_ASR, 32'h8000_0000, 31, 0, 0, 0, 1, 0); tick();
    chk("t2_asr", out_result, 32'hFFFF_FFFF);
    drive(1, OP_ROR, 1, 1, 0, 0, 0, 1, 0); tick();
    chk("t2_ror", out_result, 32'h8000_0000);
    drive(1, OP_LSR, 32'h1234_5678, 32, 0, 0, 0, 1, 0); tick();
    chk("t2_lsr0", out_result, 32'h1234_5678);

    drive(1, OP_BRL, 0, 32'h100, 0, 0, COND_EQ, 3, 32'h40); tick();
    chk("t3_taken", {31'd0, br_taken}, 1);
    chk("t3_target", br_target, 32'h100);
    chk("t3_link", out_result, 32'h44);
    drive(1, OP_MOVI, 0, 0, 0, 32'h55, 0, 4, 0); tick();
    chk("t3_squash", {31'd0, out_valid}, 0);
    drive(1, OP_BRL, 0, 32'h100, 0, 0, COND_NE, 3, 32'h40); tick();
    chk("t3_nt", {31'd0, br_taken}, 0);
    chk("t3_nt_wen", {31'd0, out_wen}, 1);

    drive(1, OP_ST, 32'h1000, 0, 32'hDEAD, 32'hFFFF_FFFC, 0, 0, 0); tick();
    chk("t4_addr", {2'd0, out_mem_addr}, 32'h3FF);
    chk("t4_wdata", out_mem_wdata, 32'hDEAD);
    chk("t4_wen", {31'd0, out_wen}, 0);

    drive(1, OP_ADDI, 100, 0, 0, 1, 0, 7, 0); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, OP_SUB, i, 1, 0, 0, 0, 2, 0); tick();
      chk("t5_hold", out_result, 101);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1, OP_ADDI, i, 0, 0, 32'h10, 0, 5'(i), 0); tick();
      chk("t5_stream", out_result, 32'h10 + i);
    end

    drive(1, OP_ADD, 1, 2, 0, 0, 0, 1, 0); out_ready = 1'b0; tick();
    #2 RSTN = 1'b0;
    #1 chk("t6_async", {31'd0, out_valid}, 0);
    m_valid = 1'b0; n_ret = 0; n_tak = 0;
    @(negedge CLK);
    RSTN = 1'b1; out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom, ($urandom_range(0, 1) != 0) ? $urandom_range(0, 40) : $urandom,
            ($urandom_range(0, 2) == 0) ? 0 : $urandom, $urandom,
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
            $urandom & 32'hFFFF_FFFC);
      out_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
